// File: rtl/jtag_master.sv
// jtag_master: command-driven JTAG master.
// Each accepted command plays one TMS/TDI sequence on the TAP, starting and
// ending in Run-Test/Idle, and returns the TDO bits it captured.
// A TLR sequence runs automatically after every reset.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// valid && ready. The producer holds valid and its payload stable until that
// edge. cmd_ready is high only in IDLE. rsp_valid, rsp_data and rsp_err stay
// stable in RSP until rsp_ready is seen.
module jtag_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEQ  = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam logic [1:0] CMD_TLR = 2'd0;
    localparam logic [1:0] CMD_IR  = 2'd1;
    localparam logic [1:0] CMD_RSV = 2'd3;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q;
    logic        prime_q;     // load the edge-0 TMS/TDI before the first rise
    logic [1:0]  type_q;
    logic [5:0]  len_q;
    logic [31:0] data_q;      // TDI bits still to shift, LSB next
    logic [5:0]  e_q;         // index of the current/next TCK rising edge
    logic [7:0]  div_q;
    logic        tck_q;
    logic        tms_q;
    logic        tdi_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_q;       // captured TDO, filled from the MSB end

    logic [5:0]  e_nx;
    logic [5:0]  pre_len;
    logic [5:0]  shift_end;
    logic [5:0]  n_total;
    logic [5:0]  rsp_align;
    logic        is_scan;
    logic        tms_nx;
    logic        shift_nx;
    logic        samp_en;
    logic        div_hit;
    logic        cmd_bad;

    // Per-edge TMS/TDI selection derived from the latched command.
    always_comb begin
        e_nx      = prime_q ? 6'd0 : (e_q + 6'd1);
        pre_len   = (type_q == CMD_IR) ? 6'd4 : 6'd3;
        shift_end = pre_len + len_q;
        is_scan   = (type_q != CMD_TLR);
        n_total   = is_scan ? (shift_end + 6'd2) : 6'd6;
        rsp_align = 6'd32 - len_q;
        div_hit   = (div_q == DIV_LAST);
        tms_nx    = 1'b0;
        if (!is_scan) begin
            tms_nx = (e_nx < 6'd5);
        end else if (e_nx < pre_len) begin
            tms_nx = (e_nx < (pre_len - 6'd2));
        end else if (e_nx < (shift_end - 6'd1)) begin
            tms_nx = 1'b0;
        end else if (e_nx <= shift_end) begin
            // last shift edge (to Exit1) and Exit1 -> Update
            tms_nx = 1'b1;
        end
        shift_nx = is_scan && (e_nx >= pre_len) && (e_nx < shift_end);
        // TDO lags one TCK, so shift bit k is read on edge pre_len+k+1
        samp_en  = is_scan && (e_q > pre_len) && (e_q <= shift_end);
        cmd_bad  = (cmd_len == 6'd0) || (cmd_len > 6'd32) || (cmd_type == CMD_RSV);
    end

    // Controller FSM, TCK divider, shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            prime_q     <= 1'b1;
            type_q      <= CMD_TLR;
            len_q       <= 6'd0;
            data_q      <= 32'd0;
            e_q         <= 6'd0;
            div_q       <= 8'd0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b0;
            tdi_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_q       <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        type_q      <= cmd_type;
                        len_q       <= cmd_len;
                        data_q      <= cmd_data;
                        rsp_q       <= 32'd0;
                        if (cmd_bad) begin
                            state_q     <= ST_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_SEQ;
                            prime_q <= 1'b1;
                        end
                    end
                end
                ST_INIT, ST_SEQ: begin
                    if (!prime_q && !tck_q && (e_q == n_total)) begin
                        // sequence complete, TCK back low
                        if (state_q == ST_INIT) begin
                            state_q     <= ST_IDLE;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            state_q     <= ST_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_q       <= rsp_q >> rsp_align;
                        end
                    end else begin
                        // TMS/TDI move only before the first rise or on a fall
                        if (prime_q || (div_hit && tck_q)) begin
                            e_q   <= e_nx;
                            tms_q <= tms_nx;
                            if (shift_nx) begin
                                tdi_q  <= data_q[0];
                                data_q <= data_q >> 1;
                            end else begin
                                tdi_q <= 1'b0;
                            end
                        end
                        if (prime_q) begin
                            prime_q <= 1'b0;
                            div_q   <= 8'd0;
                        end else if (div_hit) begin
                            div_q <= 8'd0;
                            tck_q <= ~tck_q;
                            if (!tck_q && samp_en) begin
                                rsp_q <= {tdo_i, rsp_q[31:1]};
                            end
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    prime_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_q;
    assign rsp_err     = rsp_err_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: drives jtag_master against a behavioural TAP stub
// (IR capture 0x01; IDCODE=0x02 with 0xBEEFCAFE; 8-bit scratch=0x01; else bypass)
// and checks every response against an arithmetic reference model.
module tb_jtag_master;

  localparam logic [5:0]  IR_SCR = 6'h01;
  localparam logic [5:0]  IR_IDC = 6'h02;
  localparam logic [31:0] IDCODE = 32'hBEEFCAFE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type  = 2'd0;
  logic [5:0]  cmd_len   = 6'd0;
  logic [31:0] cmd_data  = 32'd0;
  logic        rsp_ready = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err, tck_o, tms_o, tdi_o;
  logic [31:0] rsp_data;
  logic [1:0]  dbg_state;
  logic        tdo_s = 1'b0;

  jtag_master #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_s),
    .dbg_state_o(dbg_state)
  );

  // ---------------- TAP stub ----------------
  typedef enum int {T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_UPDDR,
                    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_UPDIR} tap_t;
  tap_t        tap_st = T_TLR;
  logic [31:0] sr = 32'd0;
  int          sr_w = 1;
  logic [5:0]  tap_ir = IR_IDC;
  logic [7:0]  tap_scr = 8'd0;

  always @(posedge tck_o) begin
    case (tap_st)
      T_TLR:   tap_ir = IR_IDC;
      T_CAPDR: begin
        if (tap_ir == IR_IDC) begin sr = IDCODE; sr_w = 32; end
        else if (tap_ir == IR_SCR) begin sr = {24'd0, tap_scr}; sr_w = 8; end
        else begin sr = 32'd0; sr_w = 1; end
      end
      T_CAPIR: begin sr = 32'h1; sr_w = 6; end
      T_SHDR, T_SHIR: begin
        tdo_s <= sr[0];
        sr = sr >> 1;
        sr[sr_w-1] = tdi_o;
      end
      T_UPDDR: if (tap_ir == IR_SCR) tap_scr = sr[7:0];
      T_UPDIR: tap_ir = sr[5:0];
      default: ;
    endcase
    case (tap_st)
      T_TLR:   tap_st = tms_o ? T_TLR   : T_RTI;
      T_RTI:   tap_st = tms_o ? T_SELDR : T_RTI;
      T_SELDR: tap_st = tms_o ? T_SELIR : T_CAPDR;
      T_CAPDR: tap_st = tms_o ? T_EX1DR : T_SHDR;
      T_SHDR:  tap_st = tms_o ? T_EX1DR : T_SHDR;
      T_EX1DR: tap_st = tms_o ? T_UPDDR : T_EX1DR;
      T_UPDDR: tap_st = tms_o ? T_SELDR : T_RTI;
      T_SELIR: tap_st = tms_o ? T_TLR   : T_CAPIR;
      T_CAPIR: tap_st = tms_o ? T_EX1IR : T_SHIR;
      T_SHIR:  tap_st = tms_o ? T_EX1IR : T_SHIR;
      T_EX1IR: tap_st = tms_o ? T_UPDIR : T_EX1IR;
      default: tap_st = tms_o ? T_SELDR : T_RTI;
    endcase
  end

  // ---------------- monitors ----------------
  logic tms_seen[$];
  logic tdi_seen[$];
  always @(posedge tck_o) begin
    tms_seen.push_back(tms_o);
    tdi_seen.push_back(tdi_o);
  end

  int   viol = 0;
  logic prev_tms = 1'b0;
  logic prev_tdi = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (tck_o && (tms_o !== prev_tms || tdi_o !== prev_tdi)) viol++;
      if (cmd_ready && rsp_valid) viol++;
    end
    prev_tms = tms_o;
    prev_tdi = tdi_o;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] ir_m  = IR_IDC;
  logic [7:0] scr_m = 8'd0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int len);
    return (64'd1 << len) - 64'd1;
  endfunction

  function automatic logic [63:0] to_vec(input logic q[$]);
    logic [63:0] v = '0;
    for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
    return v;
  endfunction

  // TMS per rising edge, bit i = edge i, from the per-command edge lists
  function automatic logic [63:0] exp_tms(input int t, input int len, input bit bad);
    logic [63:0] v = '0;
    int e = 0;
    if (bad) return v;
    if (t == 0) return 64'h1F;
    v[e] = 1'b1; e++;
    if (t == 1) begin v[e] = 1'b1; e++; end
    e += 2;
    e += len - 1;
    v[e] = 1'b1; e++;
    v[e] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] exp_tdi(input int t, input int len, input logic [31:0] d, input bit bad);
    logic [63:0] v = '0;
    int s;
    if (bad || t == 0) return v;
    s = (t == 1) ? 4 : 3;
    for (int k = 0; k < len; k++) v[s+k] = d[k];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!cmd_ready && n < 2000) begin @(posedge clk); #1; n++; end
    ok = cmd_ready;
  endtask

  task automatic check_reset_outs(input string tag);
    check_val(tag, {26'd0, tck_o, tms_o, tdi_o, cmd_ready, rsp_valid, rsp_err, rsp_data}, 64'd0);
  endtask

  task automatic release_reset();
    bit ok;
    tms_seen.delete();
    tdi_seen.delete();
    rst = 1'b0;
    wait_ready(ok);
    check_val("init_ready", ok, 1);
    check_val("init_edges", tms_seen.size(), 6);
    check_val("init_tms", to_vec(tms_seen), 64'h1F);
    ir_m = IR_IDC;
  endtask

  task automatic run_cmd(input int t, input int len, input logic [31:0] d, input int hold,
                         output logic [31:0] got);
    bit ok, bad, stable;
    logic [63:0] cat, exp_data;
    logic [31:0] c, snap;
    logic [1:0]  snap_st;
    int w, n, exp_edges, tt;
    bad = (t == 3) || (len == 0) || (len > 32);
    exp_data = 64'd0;
    if (!bad) begin
      if (t == 0) begin
        ir_m = IR_IDC;
      end else if (t == 1) begin
        cat = ({32'd0, d} << 6) | 64'h1;
        exp_data = cat & mask(len);
        ir_m = cat[len +: 6];
      end else begin
        if (ir_m == IR_IDC) begin w = 32; c = IDCODE; end
        else if (ir_m == IR_SCR) begin w = 8; c = {24'd0, scr_m}; end
        else begin w = 1; c = 32'd0; end
        cat = ({32'd0, d} << w) | {32'd0, c};
        exp_data = cat & mask(len);
        if (ir_m == IR_SCR) scr_m = cat[len +: 8];
      end
    end
    tt = (t == 1) ? 6 : 5;
    exp_edges = bad ? 0 : (t == 0) ? 6 : len + tt;

    tms_seen.delete();
    tdi_seen.delete();
    got = 32'd0;
    wait_ready(ok);
    check_val("cmd_ready", ok, 1);
    if (!ok) return;
    cmd_valid = 1'b1;
    cmd_type  = 2'(t);
    cmd_len   = 6'(len);
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom());
    cmd_len   = 6'($urandom());
    cmd_data  = $urandom();
    check_val("ready_drop", cmd_ready, 0);
    n = 0;
    while (!rsp_valid && n < 4000) begin @(posedge clk); #1; n++; end
    check_val("rsp_valid", rsp_valid, 1);
    got = rsp_data;
    check_val("rsp_data", rsp_data, exp_data);
    check_val("rsp_err", rsp_err, bad);
    check_val("edges", tms_seen.size(), exp_edges);
    check_val("tms_seq", to_vec(tms_seen), exp_tms(t, len, bad));
    check_val("tdi_seq", to_vec(tdi_seen), exp_tdi(t, len, d, bad));
    if (hold > 0) begin
      stable  = 1'b1;
      snap    = rsp_data;
      snap_st = dbg_state;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!rsp_valid || rsp_data !== snap || rsp_err !== bad || cmd_ready || tck_o ||
            dbg_state !== snap_st) stable = 1'b0;
      end
      check_val("rsp_hold", stable, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val("ready_back", {cmd_ready, rsp_valid}, 2'b10);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] got;
    bit ok;
    int n, t, len;
    logic [31:0] d;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset_outs");
    release_reset();

    // IDCODE after reset: 37 edges, 0xBEEFCAFE
    run_cmd(2, 32, 32'd0, 0, got);
    check_val("idcode_first", got, 64'hBEEFCAFE);

    // scratch register round trip
    run_cmd(1, 6, 32'h01, 0, got);
    check_val("ir_capture", got, 64'h01);
    run_cmd(2, 8, 32'hA5, 0, got);
    run_cmd(2, 8, 32'h3C, 0, got);
    check_val("scratch_readback", got, 64'hA5);

    // bypass
    run_cmd(1, 6, 32'h3F, 0, got);
    run_cmd(2, 4, 32'hB, 0, got);
    check_val("bypass", got, 64'h6);

    // rejected commands
    run_cmd(2, 0, 32'hFFFF_FFFF, 0, got);
    run_cmd(2, 40, 32'h1234_5678, 0, got);
    run_cmd(3, 5, 32'h1F, 0, got);
    run_cmd(0, 1, 32'h0, 0, got);

    // response held off, then IDCODE again
    run_cmd(1, 6, 32'(IR_IDC), 0, got);
    run_cmd(2, 32, $urandom(), 10, got);
    check_val("idcode_hold", got, 64'hBEEFCAFE);

    // reset on DR shift edge 10 (rising edge index 13)
    tms_seen.delete();
    tdi_seen.delete();
    wait_ready(ok);
    check_val("mid_ready", ok, 1);
    cmd_valid = 1'b1; cmd_type = 2'd2; cmd_len = 6'd32; cmd_data = $urandom();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (tms_seen.size() < 14 && n < 2000) begin @(posedge clk); #1; n++; end
    check_val("reach_shift10", tms_seen.size(), 14);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outs("midscan_reset");
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    run_cmd(2, 32, $urandom(), 0, got);
    check_val("idcode_after_rst", got, 64'hBEEFCAFE);

    // reset while a response is pending
    wait_ready(ok);
    cmd_valid = 1'b1; cmd_type = 2'd1; cmd_len = 6'd0; cmd_data = 32'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_val("pending_rsp", rsp_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outs("pending_reset");
    @(posedge clk); #1;
    release_reset();

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      t = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) len = $urandom_range(0, 63);
      else len = $urandom_range(1, 32);
      d = $urandom();
      run_cmd(t, len, d, $urandom_range(0, 3), got);
    end

    check_val("protocol", viol, 0);
    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule
